// File: rtl/if_fetch.sv
// if_fetch: IF stage. Holds the PC, fetches from a variable-latency imem, and hands
// pcadd/inst to IF/ID.
// Ports: clk, rst_n, pcwrite, branch_taken/branch_target, jump/jump_target,
// imem_req/imem_addr/imem_rdata/imem_ready, pcadd, inst, fetch_stall.
module if_fetch #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pcwrite,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  input  logic        jump,
  input  logic [7:0]  jump_target,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [7:0]  pcadd,
  output logic [31:0] inst,
  output logic        fetch_stall
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  pc, pc_nx;
  logic [7:0]  redir_pc, redir_nx;
  logic [31:0] hold_buf, hold_nx;
  logic        redirect;
  logic [7:0]  target;

  // Branch is the older instruction, so it beats a jump.
  assign redirect  = branch_taken | jump;
  assign target    = branch_taken ? branch_target : jump_target;
  assign pcadd     = pc + 8'd1;
  // The PC only moves when a request completes or in HOLD,
  // so the address stays stable while a request is pending.
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      redir_pc <= 8'h00;
      hold_buf <= 32'h0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      redir_pc <= redir_nx;
      hold_buf <= hold_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    redir_nx    = redir_pc;
    hold_nx     = hold_buf;
    imem_req    = 1'b1;
    inst        = 32'h0;
    fetch_stall = 1'b1;
    unique case (state)
      FETCH: begin
        if (imem_ready) begin
          if (redirect) begin
            pc_nx = target;
          end else begin
            inst        = imem_rdata;
            fetch_stall = 1'b0;
            if (pcwrite) begin
              pc_nx = pcadd;
            end else begin
              hold_nx  = imem_rdata;
              state_nx = HOLD;
            end
          end
        end else if (redirect) begin
          // Cannot abandon the pending request; drain it first.
          redir_nx = target;
          state_nx = DROP;
        end
      end
      HOLD: begin
        imem_req    = 1'b0;
        inst        = hold_buf;
        fetch_stall = 1'b0;
        if (redirect) begin
          pc_nx    = target;
          state_nx = FETCH;
        end else if (pcwrite) begin
          pc_nx    = pcadd;
          state_nx = FETCH;
        end
      end
      DROP: begin
        if (redirect) redir_nx = target;
        if (imem_ready) begin
          pc_nx    = redirect ? target : redir_pc;
          state_nx = FETCH;
        end
      end
      default: state_nx = FETCH;
    endcase
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed bench for if_fetch.
// Checks {imem_req, imem_addr, pcadd, inst, fetch_stall} each cycle.
module tb_if_fetch;

  logic        clk;
  logic        rst_n;
  logic        pcwrite;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        jump;
  logic [7:0]  jump_target;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [7:0]  pcadd;
  logic [31:0] inst;
  logic        fetch_stall;

  int n_cmp;
  int n_bad;

  logic [49:0] obs;
  logic [49:0] exp_v;

  if_fetch #(.RESET_PC(8'h00)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pcwrite       (pcwrite),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .pcadd         (pcadd),
    .inst          (inst),
    .fetch_stall   (fetch_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word = 0x1000 + address; garbage when no request is made.
  assign imem_rdata = imem_req ? (32'h1000 + {24'h0, imem_addr})
                               : 32'hdeadbeef;
  assign obs = {imem_req, imem_addr, pcadd, inst, fetch_stall};

  task automatic drive(input logic pw, input logic rdy,
                       input logic br, input logic [7:0] bt,
                       input logic jp, input logic [7:0] jt);
    pcwrite       = pw;
    imem_ready    = rdy;
    branch_taken  = br;
    branch_target = bt;
    jump          = jp;
    jump_target   = jt;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    #1;
    exp_v = {1'b1, 8'h00, 8'h01, 32'h0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL reset got=%h exp=%h", obs, exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_seq;
    logic [7:0] a;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
      #1;
      a = 8'(i);
      exp_v = {1'b1, a, a + 8'd1, 32'h1000 + 32'(i), 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL seq%0d got=%h exp=%h", i, obs, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_latency;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, (i == 2), 1'b0, 8'h00, 1'b0, 8'h00);
      #1;
      if (i == 2) exp_v = {1'b1, 8'h04, 8'h05, 32'h1004, 1'b0};
      else        exp_v = {1'b1, 8'h04, 8'h05, 32'h0, 1'b1};
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL lat%0d got=%h exp=%h", i, obs, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hold;
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    #1;
    exp_v = {1'b1, 8'h05, 8'h06, 32'h1005, 1'b0};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL hold_enter got=%h exp=%h", obs, exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive((i == 2), 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
      #1;
      exp_v = {1'b0, 8'h05, 8'h06, 32'h1005, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL hold%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    #1;
    exp_v = {1'b1, 8'h06, 8'h07, 32'h1006, 1'b0};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL hold_release got=%h exp=%h", obs, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_jump_drop;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h40);
    #1;
    exp_v = {1'b1, 8'h07, 8'h08, 32'h0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL jump_req got=%h exp=%h", obs, exp_v);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b1, (i == 1), 1'b0, 8'h00, 1'b0, 8'h00);
      #1;
      exp_v = {1'b1, 8'h07, 8'h08, 32'h0, 1'b1};
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL drop%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    #1;
    exp_v = {1'b1, 8'h40, 8'h41, 32'h1040, 1'b0};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL jump_target got=%h exp=%h", obs, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_branch_jump;
    drive(1'b1, 1'b1, 1'b1, 8'h10, 1'b1, 8'h20);
    #1;
    exp_v = {1'b1, 8'h41, 8'h42, 32'h0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL bj_redirect got=%h exp=%h", obs, exp_v);
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    #1;
    exp_v = {1'b1, 8'h10, 8'h11, 32'h1010, 1'b0};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL bj_target got=%h exp=%h", obs, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap_reset;
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hff);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    #1;
    exp_v = {1'b1, 8'hff, 8'h00, 32'h10ff, 1'b0};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL wrap_ff got=%h exp=%h", obs, exp_v);
    end
    @(negedge clk);
    #1;
    exp_v = {1'b1, 8'h00, 8'h01, 32'h1000, 1'b0};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL wrap_00 got=%h exp=%h", obs, exp_v);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h80);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    #1;
    exp_v = {1'b1, 8'h01, 8'h02, 32'h0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL drop_pre got=%h exp=%h", obs, exp_v);
    end
    #1;
    rst_n = 1'b0;
    #1;
    exp_v = {1'b1, 8'h00, 8'h01, 32'h0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL drop_reset got=%h exp=%h", obs, exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    #1;
    exp_v = {1'b1, 8'h00, 8'h01, 32'h1000, 1'b0};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL post_reset got=%h exp=%h", obs, exp_v);
    end
    @(negedge clk);
    #1;
    exp_v = {1'b1, 8'h01, 8'h02, 32'h1001, 1'b0};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL post_reset_nx got=%h exp=%h", obs, exp_v);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_seq();
    test_latency();
    test_hold();
    test_jump_drop();
    test_branch_jump();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID register. Holds the PC (8-bit word address), issues requests to a variable-latency instruction memory, selects the next PC (sequential, branch or jump), and presents `pcadd` (PC+1) and `inst` to IF/ID. `fetch_stall` marks cycles with no valid instruction so IF/ID loads a bubble. A one-entry hold buffer keeps a fetched instruction while the hazard unit blocks PC update.

## Interface
- `RESET_PC`, default 8'h00: PC value after reset.
- `clk` input 1: pipeline clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `pcwrite` input 1: 1 = PC may advance; 0 = hold (load-use stall).
- `branch_taken` input 1: redirect to `branch_target` (EX-resolved).
- `branch_target` input 8: branch word address.
- `jump` input 1: redirect to `jump_target` (ID-resolved).
- `jump_target` input 8: jump word address.
- `imem_req` output 1: fetch request.
- `imem_addr` output 8: fetch word address.
- `imem_rdata` input 32: instruction data, valid when `imem_ready`=1.
- `imem_ready` input 1: request completes this cycle.
- `pcadd` output 8: PC+1 of the delivered instruction, to IF/ID.
- `inst` output 32: delivered instruction, to IF/ID; 0 when not valid.
- `fetch_stall` output 1: no valid instruction this cycle; IF/ID loads a bubble.

## Operation
- Registers: `pc`[7:0], `state`, `hold_buf`[31:0], `redir_pc`[7:0].
- States: FETCH, HOLD, DROP.
- Redirect = `branch_taken | jump`. Target = `branch_target` if `branch_taken`, else `jump_target`; branch wins when both are asserted (older instruction). A redirect overrides `pcwrite`.
- Memory rule: while `imem_req`=1 and `imem_ready`=0, `imem_addr` must not change.
- FETCH:
  - `imem_req`=1, `imem_addr`=`pc`.
  - `imem_ready`=0, no redirect: stay in FETCH; `fetch_stall`=1.
  - `imem_ready`=0, redirect: `redir_pc`<=target, go to DROP; `fetch_stall`=1.
  - `imem_ready`=1, redirect: discard data, `pc`<=target, stay in FETCH; `fetch_stall`=1.
  - `imem_ready`=1, `pcwrite`=1: deliver `imem_rdata`, `pc`<=`pc`+1, stay in FETCH; `fetch_stall`=0.
  - `imem_ready`=1, `pcwrite`=0: deliver `imem_rdata` (IF/ID ignores it via `ifidwrite`), `hold_buf`<=`imem_rdata`, go to HOLD.
- HOLD:
  - `imem_req`=0; `inst`=`hold_buf`; `fetch_stall`=0.
  - Redirect: `pc`<=target, go to FETCH.
  - `pcwrite`=1: `pc`<=`pc`+1, go to FETCH.
  - Otherwise stay in HOLD.
- DROP:
  - `imem_req`=1, `imem_addr`=old `pc` (held); `fetch_stall`=1; `inst`=0.
  - A new redirect overwrites `redir_pc`.
  - On `imem_ready`=1: discard data, `pc`<=(new redirect target if present, else `redir_pc`), go to FETCH.
- `pcadd` = `pc`+1 in all states, modulo 256 (8'hFF+1 = 8'h00, no flag). The PC increment wraps the same way.
- `inst` = `imem_rdata` when delivering from FETCH, `hold_buf` in HOLD, else 32'h0.

## Timing
- Reset (asynchronous, any state, including mid-request): `pc`=`RESET_PC`, state=FETCH, `hold_buf`=0, `redir_pc`=0.
- Outputs during and right after reset: `imem_req`=1, `imem_addr`=`RESET_PC`, `pcadd`=`RESET_PC`+1, `inst`=0, `fetch_stall`=1 (unless `imem_ready`).
- An abandoned memory request at reset is not tracked; the memory must also reset.
- Outputs are combinational from state, `pc` and the memory inputs; no added latency beyond the memory. With single-cycle memory (`imem_ready` tied 1) the block delivers one instruction per cycle.
- Redirect penalty:
  - 0 bubbles when `imem_ready`=1 in the redirect cycle (fetch from the target starts next cycle).
  - Otherwise, remaining memory latency plus one cycle.
- HOLD to FETCH costs no bubble only when the next fetch completes immediately.

## Test plan
- Reset, `imem_ready`=1, `pcwrite`=1, rdata = 32'h1000+addr for 4 cycles -> `imem_addr` 0,1,2,3; `inst` 32'h1000..32'h1003; `pcadd` 1..4; `fetch_stall`=0 throughout.
- 3-cycle memory latency (ready every third cycle) -> `fetch_stall` high two of every three cycles; `imem_addr` stable while waiting.
- `pcwrite`=0 for 3 cycles at `pc`=5 -> state HOLD, `imem_req`=0, `inst` held at word 5; on release, next fetch at `pc`=6.
- `jump`=1, `jump_target`=8'h40 while a fetch is waiting, ready 2 cycles later -> DROP; data discarded; next `imem_addr`=8'h40; `fetch_stall`=1 until the 8'h40 fetch completes.
- `branch_taken`=1 (target 8'h10) and `jump`=1 (target 8'h20) in the same cycle with `imem_ready`=1 -> next `imem_addr`=8'h10.
- `pc`=8'hFF delivered -> `pcadd`=8'h00, next `imem_addr`=8'h00; async reset asserted mid-DROP -> `pc`=0, FETCH, `inst`=0 immediately.
